// File: rtl/ic_trace_arbiter.sv
// ----------------------------------------------------------------------------
// ic_trace_arbiter
//
// Shares one debug trace channel between N_REQ requesters. A round-robin
// search picks one offering requester, its payload and format code are
// latched together with a free-running cycle timestamp, and the record is
// sent out as two valid/ready beats: beat 0 = timestamp, beat 1 = payload.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   req_valid  per-requester record offer
//   req_ready  one-hot accept, only ever high while idle
//   req_fmt    per-requester 2-bit format code (HEX, DEC, CHAR, ARR)
//   req_data   per-requester payload, slice i belongs to requester i
//   out_valid  output beat valid
//   out_ready  sink accepts the beat
//   out_word   beat 0 = timestamp, beat 1 = payload
//   out_last   high on beat 1 only
//   out_src    index of the granted requester, held across both beats
//   out_fmt    latched format code, held across both beats
//   rec_cnt    count of completed records, wraps at 2^16
// ----------------------------------------------------------------------------
module ic_trace_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [2*N_REQ-1:0]        req_fmt,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_word,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    output logic [1:0]                out_fmt,
    output logic [15:0]               rec_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TS   = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   ts_q;
    logic [DATA_W-1:0]   data_q, data_d;     // payload parked for beat 1
    logic [DATA_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [1:0]          fmt_q, fmt_d;
    logic [15:0]         rec_cnt_q, rec_cnt_d;

    // Round-robin search done as two priority scans: the lowest requester at
    // or above rr_ptr wins; if none is there, the lowest requester overall
    // (the wrap-around case) wins.
    logic                hi_found, lo_found, gnt_valid;
    logic [SRC_W-1:0]    hi_idx, lo_idx, gnt_idx;
    logic [DATA_W-1:0]   hi_data, lo_data, gnt_data;
    logic [1:0]          hi_fmt, lo_fmt, gnt_fmt;

    // NOTE: every signal driven from always_comb gets a default at the top of
    // the block so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_data  = '0;
        lo_data  = '0;
        hi_fmt   = '0;
        lo_fmt   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = SRC_W'(i);
                    lo_data  = req_data[i*DATA_W +: DATA_W];
                    lo_fmt   = req_fmt[2*i +: 2];
                end
                if (!hi_found && (SRC_W'(i) >= rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = SRC_W'(i);
                    hi_data  = req_data[i*DATA_W +: DATA_W];
                    hi_fmt   = req_fmt[2*i +: 2];
                end
            end
        end
        gnt_valid = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx  : lo_idx;
        gnt_data  = hi_found ? hi_data : lo_data;
        gnt_fmt   = hi_found ? hi_fmt  : lo_fmt;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        data_d    = data_q;
        word_d    = word_q;
        last_d    = last_q;
        src_d     = src_q;
        fmt_d     = fmt_q;
        rec_cnt_d = rec_cnt_q;
        req_ready = '0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Accept is suppressed during reset: the record would be
                // dropped at the same edge, so the requester must keep it.
                if (gnt_valid && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    data_d   = gnt_data;
                    fmt_d    = gnt_fmt;
                    src_d    = gnt_idx;
                    word_d   = ts_q;              // stamp = ts in accept cycle
                    last_d   = 1'b0;
                    rr_ptr_d = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0
                                                              : gnt_idx + SRC_W'(1);
                    state_d  = ST_TS;
                end
            end
            ST_TS: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    word_d  = data_q;
                    last_d  = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rec_cnt_d = rec_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            ts_q      <= '0;
            data_q    <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            src_q     <= '0;
            fmt_q     <= '0;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            ts_q      <= ts_q + DATA_W'(1);
            data_q    <= data_d;
            word_q    <= word_d;
            last_q    <= last_d;
            src_q     <= src_d;
            fmt_q     <= fmt_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    // Beat fields are registers, so they hold through backpressure and keep
    // their last values while idle.
    assign out_word = word_q;
    assign out_last = last_q;
    assign out_src  = src_q;
    assign out_fmt  = fmt_q;
    assign rec_cnt  = rec_cnt_q;

endmodule

// File: tb/tb_ic_trace_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ic_trace_arbiter
//
// Randomized and directed stimulus for ic_trace_arbiter. A predictor decides
// from the round-robin rule which requester must be accepted each cycle and
// pushes the expected record into a scoreboard queue; an independent monitor
// compares each presented output beat against the head of that queue.
// A second 8-bit instance covers timestamp wrap-around.
// ----------------------------------------------------------------------------
module tb_ic_trace_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [N-1:0]      vld = '0;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    fmt_in = '0;
    logic [DW*N-1:0]   data_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_word;
    logic              out_last;
    logic [1:0]        out_src;
    logic [1:0]        out_fmt;
    logic [15:0]       rec_cnt;

    // 8-bit instance
    logic [N-1:0]      rv8 = '0;
    logic [N-1:0]      rr8;
    logic [2*N-1:0]    fmt8 = '0;
    logic [8*N-1:0]    data8 = '0;
    logic              ov8;
    logic              or8 = 1'b1;
    logic [7:0]        ow8;
    logic              ol8;
    logic [1:0]        os8;
    logic [1:0]        of8;
    logic [15:0]       rc8;

    ic_trace_arbiter #(.N_REQ(N), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(vld), .req_ready(req_ready),
        .req_fmt(fmt_in), .req_data(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_last(out_last),
        .out_src(out_src), .out_fmt(out_fmt), .rec_cnt(rec_cnt)
    );

    ic_trace_arbiter #(.N_REQ(N), .DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req_valid(rv8), .req_ready(rr8),
        .req_fmt(fmt8), .req_data(data8),
        .out_valid(ov8), .out_ready(or8),
        .out_word(ow8), .out_last(ol8),
        .out_src(os8), .out_fmt(of8), .rec_cnt(rc8)
    );

    int  total = 0;
    int  bad   = 0;
    bit  started = 1'b0;

    // Reference time: cycles since the last reset edge.
    logic [DW-1:0] ts_m  = '0;
    logic [7:0]    ts8_m = '0;
    int            cyc_m = 0;
    always @(posedge clk) begin
        ts_m  <= rst ? '0 : ts_m + 1;
        ts8_m <= rst ? '0 : ts8_m + 1;
        cyc_m <= cyc_m + 1;
    end

    typedef struct {
        int          src;
        logic [1:0]  fmt;
        logic [DW-1:0] data;
        logic [DW-1:0] stamp;
        int          cyc;     // accept cycle; record is visible from cyc+1
    } rec_t;

    rec_t          sbq[$];
    int            ptr_m   = 0;
    logic [15:0]   exp_cnt = '0;
    bit            beat    = 1'b0;
    logic [N-1:0]  acc     = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: whenever the arbiter has no record outstanding, the first
    // offering requester at or after the pointer (cyclically) must be taken.
    always begin : predictor
        int           win;
        logic [N-1:0] exp_rdy;
        @(posedge clk);
        #3;
        if (started) begin
            exp_rdy = '0;
            win     = -1;
            if (rst) begin
                ptr_m = 0;
            end else if (sbq.size() == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && vld[(ptr_m + k) % N]) win = (ptr_m + k) % N;
                end
                if (win >= 0) begin
                    exp_rdy[win] = 1'b1;
                    sbq.push_back('{win, fmt_in[2*win +: 2], data_in[DW*win +: DW], ts_m, cyc_m});
                    ptr_m = (win + 1) % N;
                end
            end
            check("req_ready", req_ready, exp_rdy);
        end
    end

    // Monitor: compares presented beats with the scoreboard head.
    always begin : monitor
        bit active;
        @(negedge clk);
        if (started) begin
            active = (sbq.size() != 0) && (sbq[0].cyc != cyc_m);
            check("out_valid", out_valid, active);
            check("rec_cnt", rec_cnt, exp_cnt);
            if (active && out_valid) begin
                check(beat ? "beat1_word" : "beat0_word", out_word,
                      beat ? sbq[0].data : sbq[0].stamp);
                check("out_last", out_last, beat);
                check("out_src", out_src, sbq[0].src);
                check("out_fmt", out_fmt, sbq[0].fmt);
                if (out_ready) begin
                    if (beat) begin
                        void'(sbq.pop_front());
                        exp_cnt++;
                        beat = 1'b0;
                    end else begin
                        beat = 1'b1;
                    end
                end
            end
            if (rst) begin
                sbq.delete();
                exp_cnt = '0;
                beat    = 1'b0;
            end
        end
    end

    // One cycle: capture accepts mid-cycle, then drop accepted offers.
    task automatic step();
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        vld = vld & ~acc;
    endtask

    task automatic set_req(input int i, input logic [1:0] f, input logic [DW-1:0] d);
        vld[i]            = 1'b1;
        fmt_in[2*i +: 2]  = f;
        data_in[DW*i +: DW] = d;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        g = '0;
        for (int n = 0; n < 20 && g == 0; n++) begin
            step();
            g = acc;
        end
        check("grant_seen", g != 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (vld != 0 || sbq.size() != 0); n++) step();
        check("drain_done", (vld != 0) || (sbq.size() != 0), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_beat8(input logic exp_last, input logic [7:0] exp_w, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (ov8 && ol8 == exp_last) begin
                seen = 1'b1;
                check(name, ow8, exp_w);
            end
        end
        check({name, "_seen"}, seen, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stimulus
        logic [N-1:0] g;
        int           got[5];
        int           ng;

        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_fmt", out_fmt, 0);
        check("rst_rec_cnt", rec_cnt, 0);

        // Single request raised at ts=5
        for (int n = 0; n < 20 && ts_m != 5; n++) begin
            @(posedge clk);
            #1;
        end
        set_req(2, 2'd1, 32'hDEADBEEF);
        step();
        check("t1_grant", acc, 4'b0100);
        check("t1_b0_word", out_word, 5);
        check("t1_b0_src", out_src, 2);
        check("t1_b0_fmt", out_fmt, 1);
        check("t1_b0_last", out_last, 0);
        step();
        check("t1_b1_word", out_word, 32'hDEADBEEF);
        check("t1_b1_last", out_last, 1);
        step();
        check("t1_rec_cnt", rec_cnt, 1);

        // All four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'($urandom_range(0, 3)), $urandom);
        ng = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (acc != 0) begin
                if (ng < 5) got[ng] = $clog2(acc);
                ng++;
                if (ng < 5) set_req($clog2(acc), 2'($urandom_range(0, 3)), $urandom);
            end
        end
        check("t2_grants", ng, 5);
        for (int k = 0; k < 5; k++) check("t2_order", got[k], k % N);
        check("t2_rec_cnt", rec_cnt, 5);
        vld = '0;
        drain();

        // Backpressure during beat 0
        out_ready = 1'b0;
        set_req(0, 2'd3, 32'h0BAD_F00D);
        wait_grant(g);
        set_req(1, 2'd0, 32'h1111_2222);
        set_req(2, 2'd2, 32'h3333_4444);
        for (int c = 0; c < 10; c++) begin
            step();
            check("t3_no_grant", acc, 0);
        end
        out_ready = 1'b1;
        drain();

        // Pointer wrap
        set_req(3, 2'd1, 32'h0000_0003);
        wait_grant(g);
        check("t4_grant3", g, 4'b1000);
        set_req(1, 2'd1, 32'h0000_0001);
        set_req(0, 2'd1, 32'h0000_0000);
        wait_grant(g);
        check("t4_grant0", g, 4'b0001);
        wait_grant(g);
        check("t4_grant1", g, 4'b0010);
        drain();

        // Reset while beat 1 is pending
        out_ready = 1'b0;
        set_req(2, 2'd2, 32'hCAFE_0002);
        wait_grant(g);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("t5_in_data", out_last, 1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'($urandom_range(0, 3)), $urandom);
        step();
        rst = 1'b0;
        check("t5_valid_after_rst", out_valid, 0);
        check("t5_cnt_after_rst", rec_cnt, 0);
        out_ready = 1'b1;
        wait_grant(g);
        check("t5_first_grant", g, 4'b0001);
        check("t5_stamp", out_word, 0);
        check("t5_src", out_src, 0);
        drain();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 2'($urandom_range(0, 3)), $urandom);
            end
            step();
        end
        out_ready = 1'b1;
        drain();

        // Timestamp wrap on the 8-bit instance
        for (int n = 0; n < 400 && ts8_m != 8'd255; n++) begin
            @(posedge clk);
            #1;
        end
        rv8           = 4'b0001;
        data8[7:0]    = 8'hA5;
        @(negedge clk);
        check("t6_grant", rr8, 4'b0001);
        @(posedge clk);
        #1;
        rv8           = 4'b0010;
        data8[15:8]   = 8'h5A;
        wait_beat8(1'b0, 8'd255, "t6_stamp_a");
        wait_beat8(1'b1, 8'hA5, "t6_data_a");
        wait_beat8(1'b0, 8'd2, "t6_stamp_b");
        @(posedge clk);
        #1;
        rv8 = '0;
        wait_beat8(1'b1, 8'h5A, "t6_data_b");
        @(posedge clk);
        #1;
        check("t6_rec_cnt", rc8, 2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
